instr_encoder_loader: RTL and testbench

Sequential instruction encoder and program loader for the single-cycle ARM-subset core. It accepts decoded instruction fields over a valid/ready handshake and packs each request into the 32-bit word format the core's main decoder consumes: Op in [27:26], Funct in [25:20], I bit, S/L bit and link bit. It then writes the words to consecutive instruction-memory addresses. It sits between the debug/boot host interface and the instruction memory write port, and is used to load programs before the core is released from reset.

---
 rtl/instr_encoder_loader_pkg.sv | 45 ++++
 rtl/instr_encoder_loader_pack.sv | 52 +++++
 rtl/instr_encoder_loader.sv | 146 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: op codes, FSM states,
// field positions of the packed instruction word and the request bundle.
package instr_encoder_loader_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam int COND_LSB  = 28;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_LSB = 20;
  localparam int I_BIT     = 25;
  localparam int CMD_LSB   = 21;
  localparam int S_BIT     = 20;
  localparam int L_BIT     = 20;
  localparam int LINK_BIT  = 24;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;

  // Memory funct: immediate offset, pre-indexed, up, word, no writeback
  localparam logic [5:0] MEM_FUNCT = 6'b011000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  cond;
    logic        imm_en;
    logic [3:0]  cmd;
    logic        s;
    logic        load;
    logic        link;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm;
  } req_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational field-to-word packer with legality check for the ARM-subset
// main decoder format (module instr_pack).
import instr_encoder_loader_pkg::*;

module instr_pack (
  input  req_t        req,
  output logic [31:0] word,
  output logic        legal
);

  // Pack fields by op class and flag unencodable requests
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b0;
    word[COND_LSB +: 4] = req.cond;
    word[OP_LSB +: 2]   = req.op;
    case (req.op)
      OP_DP: begin
        word[I_BIT]         = req.imm_en;
        word[CMD_LSB +: 4]  = req.cmd;
        word[S_BIT]         = req.s;
        word[RN_LSB +: 4]   = req.rn;
        word[RD_LSB +: 4]   = req.rd;
        if (req.imm_en) begin
          word[11:0] = {4'h0, req.imm[7:0]};
          legal      = (req.imm[23:8] == 16'h0000);
        end else begin
          word[11:0] = {8'h00, req.rm};
          legal      = 1'b1;
        end
      end
      OP_MEM: begin
        word[FUNCT_LSB +: 6] = MEM_FUNCT;
        word[L_BIT]          = req.load;
        word[RN_LSB +: 4]    = req.rn;
        word[RD_LSB +: 4]    = req.rd;
        word[11:0]           = req.imm[11:0];
        legal                = (req.imm[23:12] == 12'h000);
      end
      OP_BR: begin
        word[I_BIT]    = 1'b1;
        word[LINK_BIT] = req.link;
        word[23:0]     = req.imm;
        legal          = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder and program loader into instruction memory.
// Optional running XOR checksum of written words: ENCODER_CHECKSUM_EN.
import instr_encoder_loader_pkg::*;

module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [1:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_imm_en,
  input  logic [3:0]        req_cmd,
  input  logic              req_s,
  input  logic              req_load,
  input  logic              req_link,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rm,
  input  logic [23:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t      state_r;
  logic        we_r;
  logic        last_r;
  req_t        req_s_bundle;
  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;

  assign req_s_bundle = '{op: req_op, cond: req_cond, imm_en: req_imm_en, cmd: req_cmd,
                          s: req_s, load: req_load, link: req_link, rn: req_rn,
                          rd: req_rd, rm: req_rm, imm: req_imm};

  instr_pack u_pack (
    .req   (req_s_bundle),
    .word  (pack_word),
    .legal (pack_legal)
  );

  assign accept = req_valid && req_ready;
  // A start landing in the write cycle cancels that write
  assign imem_we = we_r && !start;

  // Loader FSM with registered handshake, memory-port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      req_ready  <= 1'b0;
      we_r       <= 1'b0;
      last_r     <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
    end else if (start) begin
      state_r   <= ST_ACCEPT;
      req_ready <= 1'b1;
      we_r      <= 1'b0;
      last_r    <= 1'b0;
      imem_addr <= base_addr;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
    end else begin
      case (state_r)
        ST_ACCEPT: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (!pack_legal || count == DEPTH_C) begin
              state_r <= ST_ERR;
              error   <= 1'b1;
            end else begin
              state_r    <= ST_WRITE;
              we_r       <= 1'b1;
              imem_wdata <= pack_word;
              last_r     <= req_last;
            end
          end else begin
            state_r <= ST_ACCEPT;
          end
        end
        ST_WRITE: begin
          we_r      <= 1'b0;
          imem_addr <= imem_addr + ADDR_W'(1);
          if (count != DEPTH_C) begin
            count <= count + (ADDR_W+1)'(1);
          end else begin
            count <= count;
          end
          if (last_r) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r   <= ST_ACCEPT;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: begin
          state_r <= state_r;
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b0;
          we_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running XOR of every word actually strobed into memory
  always_ff @(posedge clk) begin
    if (reset || start) begin
      checksum_r <= 32'h0000_0000;
    end else if (imem_we) begin
      checksum_r <= checksum_r ^ imem_wdata;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever imem_we is seen.
import instr_encoder_loader_pkg::*;

module tb_instr_encoder_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, start, req_valid, req_last;
  logic [ADDR_W-1:0] base_addr;
  logic              req_ready, imem_we, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata, checksum;
  logic [ADDR_W:0]   count;
  req_t              req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;
  exp_t exp_q[$];

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_op(req.op), .req_cond(req.cond), .req_imm_en(req.imm_en),
    .req_cmd(req.cmd), .req_s(req.s), .req_load(req.load), .req_link(req.link),
    .req_rn(req.rn), .req_rd(req.rd), .req_rm(req.rm), .req_imm(req.imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .error(error), .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  function automatic req_t mk(input logic [1:0] op, input logic imm_en, input logic [3:0] cmd,
                              input logic s, input logic load, input logic link,
                              input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                              input logic [23:0] imm);
    req_t r;
    r = '{op: op, cond: 4'hE, imm_en: imm_en, cmd: cmd, s: s, load: load, link: link,
          rn: rn, rd: rd, rm: rm, imm: imm};
    return r;
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one request; returns whether it was accepted within the budget
  task automatic send(input req_t r, input logic last, input bit push,
                      input logic [ADDR_W-1:0] eaddr, input logic [31:0] eword,
                      input int budget, output bit acc);
    exp_t e;
    req = r;
    req_last = last;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        acc = 1'b1;
        if (push) begin
          e.addr = eaddr;
          e.data = eword;
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic send_ok(input req_t r, input logic last, input bit push,
                         input logic [ADDR_W-1:0] eaddr, input logic [31:0] eword);
    bit acc;
    send(r, last, push, eaddr, eword, 20, acc);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(done), 32'd1);
  endtask

  task automatic wait_error();
    int n;
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("error", 32'(error), 32'd1);
  endtask

  req_t add_r, ldr_r, bl_r, b_r, ill_r, dpbig_r;
  bit   acc_b;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_last = 1'b0;
    req = '0;
    add_r   = mk(OP_DP,  1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0);
    ldr_r   = mk(OP_MEM, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000004);
    bl_r    = mk(OP_BR,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 24'h000010);
    b_r     = mk(OP_BR,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000000);
    ill_r   = mk(2'b11,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h0);
    dpbig_r = mk(OP_DP,  1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000100);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_checksum", checksum, 32'h0);

    // Single data-processing register-form write
    do_start(6'd0);
    send_ok(add_r, 1'b1, 1'b1, 6'd0, 32'hE0812003);
    wait_done();
    chk("dp_count", 32'(count), 32'd1);

    // Memory load then branch-with-link
    do_start(6'd0);
    send_ok(ldr_r, 1'b0, 1'b1, 6'd0, 32'hE5901004);
    send_ok(bl_r, 1'b1, 1'b1, 6'd1, 32'hEB000010);
    wait_done();
    chk("mb_count", 32'(count), 32'd2);

    // Checksum of two words
    do_start(6'd0);
    send_ok(add_r, 1'b0, 1'b1, 6'd0, 32'hE0812003);
    send_ok(ldr_r, 1'b1, 1'b1, 6'd1, 32'hE5901004);
    wait_done();
`ifdef ENCODER_CHECKSUM_EN
    chk("checksum", checksum, 32'h05113007);
`else
    chk("checksum", checksum, 32'h00000000);
`endif

    // Address wrap at the top of the word space
    do_start(6'd63);
    send_ok(add_r, 1'b0, 1'b1, 6'd63, 32'hE0812003);
    send_ok(b_r, 1'b1, 1'b1, 6'd0, 32'hEA000000);
    wait_done();
    chk("wrap_count", 32'(count), 32'd2);

    // Illegal op: no write, sticky error, further requests ignored
    do_start(6'd5);
    send_ok(ill_r, 1'b0, 1'b0, 6'd0, 32'h0);
    wait_error();
    chk("ill_done", 32'(done), 32'd0);
    chk("ill_ready", 32'(req_ready), 32'd0);
    send(add_r, 1'b0, 1'b1, 6'd5, 32'hE0812003, 5, acc_b);
    chk("ill_ignored", 32'(acc_b), 32'd0);
    if (!acc_b) void'(exp_q.pop_back());
    chk("ill_count", 32'(count), 32'd0);

    // Data-processing immediate that does not fit in 8 bits
    do_start(6'd0);
    send_ok(dpbig_r, 1'b0, 1'b0, 6'd0, 32'h0);
    wait_error();
    chk("dpbig_count", 32'(count), 32'd0);

    // Overflow: DEPTH words fit, the next request errors
    do_start(6'd10);
    for (int k = 1; k <= DEPTH; k++) begin
      req_t mv;
      mv = mk(OP_DP, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 4'(k), 4'd0, 24'(k));
      send_ok(mv, 1'b0, 1'b1, 6'(10 + k - 1), 32'hE3A00000 | (32'(k) << 12) | 32'(k));
    end
    send_ok(add_r, 1'b0, 1'b0, 6'd0, 32'h0);
    wait_error();
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_done", 32'(done), 32'd0);

    // Restart during the write cycle drops the pending write
    do_start(6'd0);
    send_ok(add_r, 1'b0, 1'b0, 6'd0, 32'h0);
    start = 1'b1;
    base_addr = 6'd20;
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_ready", 32'(req_ready), 32'd1);
    send_ok(ldr_r, 1'b1, 1'b1, 6'd20, 32'hE5901004);
    wait_done();
    chk("restart_after_count", 32'(count), 32'd1);
`ifdef ENCODER_CHECKSUM_EN
    chk("restart_checksum", checksum, 32'hE5901004);
`else
    chk("restart_checksum", checksum, 32'h00000000);
`endif

    // Reset beats a simultaneous start
    do_start(6'd0);
    send_ok(ill_r, 1'b0, 1'b0, 6'd0, 32'h0);
    wait_error();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    base_addr = 6'd7;
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rw_ready", 32'(req_ready), 32'd0);
    chk("rw_error", 32'(error), 32'd0);
    chk("rw_addr", 32'(imem_addr), 32'd0);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
